// File: rtl/registrador_desloc_param.sv
// Universal shift register (hold/shift/rotate/load, both directions) for the LED-matrix data path.
// A step counter reloads load_data every PERIOD shift/rotate steps and pulses frame_done.
module registrador_desloc_param #(
  parameter int unsigned       WIDTH     = 7,
  parameter int unsigned       PERIOD    = 7,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  localparam int unsigned      CW        = (PERIOD == 0) ? 1 : $clog2(PERIOD + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] q,
  output logic             serial_out,
  output logic             frame_done,
  output logic [CW-1:0]    step_cnt
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_SHIFT = 2'b01;
  localparam logic [1:0] MODE_ROT   = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  logic [WIDTH-1:0] q_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             fd_nxt;
  logic             reload_due;
  logic             ins_bit;

  // Bit leaving the register on the side the data is moving toward.
  assign serial_out = dir ? q[0] : q[WIDTH-1];

  // Next-state selection; the counter only advances on real shift/rotate steps.
  always_comb begin
    q_nxt      = q;
    cnt_nxt    = step_cnt;
    fd_nxt     = 1'b0;
    reload_due = (PERIOD != 0) && (step_cnt == CW'(PERIOD - 1));
    ins_bit    = (mode == MODE_ROT) ? (dir ? q[0] : q[WIDTH-1]) : serial_in;
    if (en) begin
      case (mode)
        MODE_LOAD: begin
          q_nxt   = load_data;
          cnt_nxt = '0;
        end
        MODE_SHIFT, MODE_ROT: begin
          if (reload_due) begin
            q_nxt   = load_data;
            cnt_nxt = '0;
            fd_nxt  = 1'b1;
          end else begin
            q_nxt = dir ? {ins_bit, q[WIDTH-1:1]} : {q[WIDTH-2:0], ins_bit};
            if (PERIOD != 0) cnt_nxt = step_cnt + CW'(1);
          end
        end
        MODE_HOLD: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q          <= RESET_VAL;
      step_cnt   <= '0;
      frame_done <= 1'b0;
    end else begin
      q          <= q_nxt;
      step_cnt   <= cnt_nxt;
      frame_done <= fd_nxt;
    end
  end

endmodule
